dspl_arbiter: RTL and testbench

Time-shares the 8-digit display path between four requesters (producer, consumer, FIFO monitor, debug) in the GALS producer/consumer design. Each requester offers a 16-bit word; the arbiter grants the display round-robin, latches the winner's word, and holds it for a minimum visible time. It drives `data_2` and `module_sig` of the display mux, with `module_sig` carrying the owner's index.

---
 rtl/dspl_pkg.sv | 7 +
 rtl/rr_pick.sv | 18 +
 rtl/dspl_arbiter.sv | 77 +++++++
 tb/tb_dspl_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dspl_pkg.sv
// dspl_pkg: shared types and sizes for the display arbiter.
package dspl_pkg;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    typedef enum logic {IDLE, SHOW} arb_state_t;
    typedef logic [15:0] dword_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick scanning from last+1 upward, modulo NREQ.
module rr_pick
    import dspl_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);
    always_comb begin
        grant_idx = last;
        any       = |req;
        // Descending scan so the nearest requester after last wins; offset NREQ is last itself.
        for (int k = NREQ; k >= 1; k--) begin
            if (req[IDW'(32'(last) + k)]) grant_idx = IDW'(32'(last) + k);
        end
    end
endmodule

// File: rtl/dspl_arbiter.sv
// dspl_arbiter: round-robin owner of the display path with a minimum hold time per grant.
module dspl_arbiter
    import dspl_pkg::*;
#(
    parameter int HOLD = 100_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*16-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output dword_t               data_2,
    output logic [IDW-1:0]       module_sig,
    output logic                 busy
);
    localparam int            CW   = HOLD > 1 ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LOAD = CW'(HOLD - 1);
    arb_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  last_q, last_d, own_q, own_d, win;
    dword_t          data_q, data_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            any, grant;
    rr_pick u_pick (
        .req      (req),
        .last     (last_q),
        .grant_idx(win),
        .any      (any)
    );
    // A grant happens from IDLE or at expiry; refresh only applies while the timer still runs.
    assign grant = (state_q == IDLE || cnt_q == '0) && any;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        data_d  = data_q;
        ack_d   = '0;
        if (grant) begin
            state_d = SHOW;
            cnt_d   = LOAD;
            last_d  = win;
            own_d   = win;
            data_d  = req_data[{win, 4'b0} +: 16];
            ack_d   = NREQ'(1) << win;
        end else if (state_q == SHOW && cnt_q == '0) begin
            state_d = IDLE;
        end else if (state_q == SHOW) begin
            cnt_d = cnt_q - 1'b1;
            if (req[own_q]) begin
                data_d = req_data[{own_q, 4'b0} +: 16];
                ack_d  = NREQ'(1) << own_q;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
            own_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            own_q   <= own_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end
    assign ack        = ack_q;
    assign data_2     = data_q;
    assign module_sig = own_q;
    assign busy       = state_q == SHOW;
endmodule

// File: tb/tb_dspl_arbiter.sv
// tb_dspl_arbiter: directed checks of grant order, hold timing, refresh, reset and HOLD=1.
module tb_dspl_arbiter;
    logic        clock = 0;
    logic        reset = 1;
    logic [3:0]  req = 0, req1 = 0;
    logic [63:0] req_data = 0, req_data1 = 0;
    logic [3:0]  ack, ack1;
    logic [15:0] data_2, data_21;
    logic [1:0]  module_sig, module_sig1;
    logic        busy, busy1;
    int checks = 0;
    int failures = 0;

    dspl_arbiter #(.HOLD(4)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .ack(ack), .data_2(data_2), .module_sig(module_sig), .busy(busy)
    );
    dspl_arbiter #(.HOLD(1)) dut1 (
        .clock(clock), .reset(reset), .req(req1), .req_data(req_data1),
        .ack(ack1), .data_2(data_21), .module_sig(module_sig1), .busy(busy1)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        req = 0;
        req1 = 0;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (data_2 !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_2); end
        checks++; if (module_sig !== 2'd0) begin failures++; $display("FAIL reset_sig got=%0d exp=0", module_sig); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 0;
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0001;
        req_data[15:0] = 16'h1234;
        step();
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL basic_ack got=%b exp=0001", ack); end
        checks++; if (data_2 !== 16'h1234) begin failures++; $display("FAIL basic_data got=%h exp=1234", data_2); end
        checks++; if (module_sig !== 2'd0) begin failures++; $display("FAIL basic_sig got=%0d exp=0", module_sig); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        req = 0;
        step();
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL basic_ack_pulse got=%b exp=0000", ack); end
        step();
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_hold got=%b exp=1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
        checks++; if (data_2 !== 16'h1234) begin failures++; $display("FAIL basic_data_keep got=%h exp=1234", data_2); end
    endtask

    task automatic test_round_robin();
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[16*i +: 16] = 16'hA000 + 16'(i);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) begin
                for (int c = 0; c < 3; c++) begin
                    step();
                    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rr_gap n=%0d c=%0d got=%b exp=0000", n, c, ack); end
                end
            end
            step();
            w = 16'hA000 + 16'(n % 4);
            checks++; if (ack !== 4'(1 << (n % 4))) begin failures++; $display("FAIL rr_ack n=%0d got=%b exp=%b", n, ack, 4'(1 << (n % 4))); end
            checks++; if (module_sig !== 2'(n % 4)) begin failures++; $display("FAIL rr_sig n=%0d got=%0d exp=%0d", n, module_sig, n % 4); end
            checks++; if (data_2 !== w) begin failures++; $display("FAIL rr_data n=%0d got=%h exp=%h", n, data_2, w); end
            req = 4'b1111 & ~4'(1 << (n % 4));
        end
        req = 0;
    endtask

    task automatic test_refresh();
        do_reset();
        req = 4'b0100;
        req_data[47:32] = 16'h1111;
        step();
        checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL ref_grant got=%b exp=0100", ack); end
        req = 0;
        step();
        req = 4'b0100;
        req_data[47:32] = 16'hBEEF;
        step();
        checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL ref_ack got=%b exp=0100", ack); end
        checks++; if (data_2 !== 16'hBEEF) begin failures++; $display("FAIL ref_data got=%h exp=beef", data_2); end
        req = 0;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ref_busy_hold got=%b exp=1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ref_busy_fall got=%b exp=0", busy); end
        checks++; if (data_2 !== 16'hBEEF) begin failures++; $display("FAIL ref_data_keep got=%h exp=beef", data_2); end
    endtask

    task automatic test_contention();
        do_reset();
        req_data[31:16] = 16'h1111;
        req_data[63:48] = 16'h3333;
        req = 4'b0010;
        step();
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL cont_grant1 got=%b exp=0010", ack); end
        req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL cont_ignored c=%0d got=%b exp=0000", c, ack); end
        end
        req = 4'b1010;
        step();
        checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL cont_expiry_ack got=%b exp=1000", ack); end
        checks++; if (module_sig !== 2'd3) begin failures++; $display("FAIL cont_expiry_sig got=%0d exp=3", module_sig); end
        checks++; if (data_2 !== 16'h3333) begin failures++; $display("FAIL cont_expiry_data got=%h exp=3333", data_2); end
        req = 4'b0010;
        step();
        step();
        step();
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL cont_pending got=%b exp=0000", ack); end
        step();
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL cont_next_ack got=%b exp=0010", ack); end
        checks++; if (module_sig !== 2'd1) begin failures++; $display("FAIL cont_next_sig got=%0d exp=1", module_sig); end
        req = 0;
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        req = 4'b0001;
        req_data[15:0] = 16'h5555;
        step();
        req = 0;
        step();
        reset = 1;
        req = 4'b1000;
        req_data[63:48] = 16'h7777;
        step();
        checks++; if (data_2 !== 16'h0000) begin failures++; $display("FAIL mid_data got=%h exp=0000", data_2); end
        checks++; if (module_sig !== 2'd0) begin failures++; $display("FAIL mid_sig got=%0d exp=0", module_sig); end
        checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL mid_ack got=%b exp=0000", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        reset = 0;
        step();
        checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL mid_regrant_ack got=%b exp=1000", ack); end
        checks++; if (module_sig !== 2'd3) begin failures++; $display("FAIL mid_regrant_sig got=%0d exp=3", module_sig); end
        checks++; if (data_2 !== 16'h7777) begin failures++; $display("FAIL mid_regrant_data got=%h exp=7777", data_2); end
        req = 0;
    endtask

    task automatic test_hold1();
        logic [3:0] exp;
        do_reset();
        req_data1[15:0]  = 16'h00AA;
        req_data1[31:16] = 16'h00BB;
        req1 = 4'b0011;
        for (int n = 0; n < 6; n++) begin
            step();
            exp = (n % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++; if (ack1 !== exp) begin failures++; $display("FAIL h1_ack n=%0d got=%b exp=%b", n, ack1, exp); end
            checks++; if (data_21 !== ((n % 2 == 0) ? 16'h00AA : 16'h00BB)) begin failures++; $display("FAIL h1_data n=%0d got=%h", n, data_21); end
        end
        req1 = 0;
        step();
        step();
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL h1_idle got=%b exp=0", busy1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_refresh();
        test_contention();
        test_reset_mid_show();
        test_hold1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
